// File: rtl/acc_core_pkg.sv
// Shared opcode definitions and instruction decode for the parametrised accumulator core.
package acc_core_pkg;

    typedef enum logic [3:0] {
        OP_ADD, OP_ADC, OP_NAND, OP_XOR,
        OP_ADDI, OP_NANDI, OP_XORI,
        OP_LOAD, OP_STORE, OP_BR, OP_NOP
    } op_e;

    localparam logic [3:0] F_ADD   = 4'b0000;
    localparam logic [3:0] F_ADC   = 4'b0001;
    localparam logic [3:0] F_NAND  = 4'b0010;
    localparam logic [3:0] F_XOR   = 4'b0100;
    localparam logic [3:0] F_LOAD  = 4'b1110;
    localparam logic [3:0] F_STORE = 4'b1111;
    localparam logic [2:0] F_ADDI  = 3'b100;
    localparam logic [2:0] F_NANDI = 3'b101;
    localparam logic [2:0] F_XORI  = 3'b110;

    // Immediate forms are matched on f[6:4] first; everything else falls to the f[6:3] table.
    function automatic op_e decode(input logic br, input logic [6:0] f);
        op_e op;
        op = OP_NOP;
        if (br) begin
            op = OP_BR;
        end else begin
            case (f[6:4])
                F_ADDI:  op = OP_ADDI;
                F_NANDI: op = OP_NANDI;
                F_XORI:  op = OP_XORI;
                default: begin
                    case (f[6:3])
                        F_ADD:   op = OP_ADD;
                        F_ADC:   op = OP_ADC;
                        F_NAND:  op = OP_NAND;
                        F_XOR:   op = OP_XOR;
                        F_LOAD:  op = OP_LOAD;
                        F_STORE: op = OP_STORE;
                        default: op = OP_NOP;
                    endcase
                end
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/acc_core_p_if.sv
// Fetch and I/O bundle between the core, the instruction ROM and the port pins.
interface acc_core_p_if #(
    parameter int DATA_W = 4,
    parameter int PC_W   = 7
);
    logic              IVALID;
    logic [PC_W:0]     INSTR;
    logic [DATA_W-1:0] IPORT;
    logic [DATA_W-1:0] OPORT;
    logic [PC_W-1:0]   PC;

    modport master (input IVALID, input INSTR, input IPORT, output OPORT, output PC);
    modport slave  (output IVALID, output INSTR, output IPORT, input OPORT, input PC);
endinterface

// File: rtl/acc_core_alu.sv
// Combinational ALU: result and carry for one decoded operation.
module acc_core_alu
    import acc_core_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  op_e               op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] operand_i,
    input  logic              c_i,
    output logic [DATA_W-1:0] res_o,
    output logic              c_o
);

    logic [DATA_W:0] sum_s;

    // Result select; operations that are not additions pass the carry through.
    always_comb begin
        sum_s = {1'b0, a_i} + {1'b0, operand_i}
              + {{DATA_W{1'b0}}, ((op_i == OP_ADC) ? c_i : 1'b0)};
        res_o = a_i;
        c_o   = c_i;
        case (op_i)
            OP_ADD, OP_ADC, OP_ADDI: begin
                res_o = sum_s[DATA_W-1:0];
                c_o   = sum_s[DATA_W];
            end
            OP_NAND, OP_NANDI: res_o = ~(a_i & operand_i);
            OP_XOR, OP_XORI:   res_o = a_i ^ operand_i;
            OP_LOAD:           res_o = operand_i;
            default: begin
                res_o = a_i;
                c_o   = c_i;
            end
        endcase
    end

endmodule

// File: rtl/acc_core_p.sv
// Single-issue accumulator core: holds PC, A, C, OPORT and r2..r7, executes one instruction per valid cycle.
module acc_core_p
    import acc_core_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int PC_W    = 7,
    parameter int BR_COND = 0
) (
    input  logic         CLK,
    input  logic         RST,
    acc_core_p_if.master bus
);

    logic [DATA_W-1:0] a_q, a_d;
    logic              c_q, c_d;
    logic [DATA_W-1:0] oport_q, oport_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] regs_q [2:7];

    op_e               op_s;
    logic [2:0]        rrr_s;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] rval_s;
    logic [DATA_W-1:0] operand_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_c_s;
    logic              br_cond_s;
    logic              reg_we_s;

    assign op_s      = decode(bus.INSTR[PC_W], bus.INSTR[6:0]);
    assign rrr_s     = bus.INSTR[2:0];
    assign imm_s     = DATA_W'(bus.INSTR[3:0]);
    assign br_cond_s = (BR_COND != 0) ? c_q : a_q[DATA_W-1];

    // Register-file read (r0 is the live input port) and immediate/register operand select.
    always_comb begin
        rval_s = '0;
        case (rrr_s)
            3'd0:    rval_s = bus.IPORT;
            3'd1:    rval_s = oport_q;
            default: rval_s = regs_q[rrr_s];
        endcase
        if ((op_s == OP_ADDI) || (op_s == OP_NANDI) || (op_s == OP_XORI)) begin
            operand_s = imm_s;
        end else begin
            operand_s = rval_s;
        end
    end

    acc_core_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i      (op_s),
        .a_i       (a_q),
        .operand_i (operand_s),
        .c_i       (c_q),
        .res_o     (alu_res_s),
        .c_o       (alu_c_s)
    );

    // Next-state for PC, accumulator, carry, output port and register write enable.
    always_comb begin
        a_d      = alu_res_s;
        c_d      = alu_c_s;
        oport_d  = oport_q;
        pc_d     = pc_q + PC_W'(1);
        reg_we_s = 1'b0;
        case (op_s)
            OP_BR: begin
                if (br_cond_s) begin
                    pc_d = bus.INSTR[PC_W-1:0];
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            OP_STORE: begin
                if (rrr_s == 3'd1) begin
                    oport_d = a_q;
                end else if (rrr_s != 3'd0) begin
                    reg_we_s = 1'b1;
                end else begin
                    reg_we_s = 1'b0;
                end
            end
            default: reg_we_s = 1'b0;
        endcase
    end

    // Architectural state; a low IVALID freezes everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q     <= '0;
            c_q     <= 1'b0;
            oport_q <= '0;
            pc_q    <= '0;
        end else if (bus.IVALID) begin
            a_q     <= a_d;
            c_q     <= c_d;
            oport_q <= oport_d;
            pc_q    <= pc_d;
        end
    end

    // General registers r2..r7.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 2; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.IVALID && reg_we_s) begin
            regs_q[rrr_s] <= a_q;
        end
    end

    assign bus.PC    = pc_q;
    assign bus.OPORT = oport_q;

endmodule

// File: tb/tb_acc_core_p.sv
// Bench for acc_core_p: a 4/7 legacy-branch core and an 8/9 carry-branch core against an arithmetic ISA model.
module tb_acc_core_p;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    acc_core_p_if #(.DATA_W(4), .PC_W(7)) bus0 ();
    acc_core_p_if #(.DATA_W(8), .PC_W(9)) bus1 ();

    acc_core_p #(.DATA_W(4), .PC_W(7), .BR_COND(0)) dut0 (.CLK(clk), .RST(rst), .bus(bus0));
    acc_core_p #(.DATA_W(8), .PC_W(9), .BR_COND(1)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));

    int checks   = 0;
    int failures = 0;

    int unsigned m_a [2];
    int unsigned m_c [2];
    int unsigned m_op[2];
    int unsigned m_pc[2];
    int unsigned m_r [2][8];

    function automatic int dw(int d);  return (d == 0) ? 4 : 8; endfunction
    function automatic int pw(int d);  return (d == 0) ? 7 : 9; endfunction
    function automatic int brc(int d); return (d == 0) ? 0 : 1; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_a[d] = 0; m_c[d] = 0; m_op[d] = 0; m_pc[d] = 0;
            for (int r = 0; r < 8; r++) m_r[d][r] = 0;
        end
    endtask

    task automatic model_exec(input int d, input int unsigned instr, input int unsigned ip);
        int unsigned dmask, pmask, f, r, imm, src, sum, cond;
        dmask = (32'd1 << dw(d)) - 32'd1;
        pmask = (32'd1 << pw(d)) - 32'd1;
        if (((instr >> pw(d)) & 32'd1) != 0) begin
            cond = (brc(d) != 0) ? m_c[d] : ((m_a[d] >> (dw(d) - 1)) & 32'd1);
            m_pc[d] = (cond != 0) ? (instr & pmask) : ((m_pc[d] + 32'd1) & pmask);
            return;
        end
        f   = instr & 32'h7F;
        r   = f & 32'd7;
        imm = f & 32'd15;
        src = (r == 0) ? (ip & dmask) : (r == 1) ? m_op[d] : m_r[d][r];
        case (f >> 4)
            4: begin sum = m_a[d] + imm; m_a[d] = sum & dmask; m_c[d] = (sum >> dw(d)) & 32'd1; end
            5: m_a[d] = ~(m_a[d] & imm) & dmask;
            6: m_a[d] = (m_a[d] ^ imm) & dmask;
            default: begin
                case (f >> 3)
                    0: begin sum = m_a[d] + src; m_a[d] = sum & dmask; m_c[d] = (sum >> dw(d)) & 32'd1; end
                    1: begin sum = m_a[d] + src + m_c[d]; m_a[d] = sum & dmask; m_c[d] = (sum >> dw(d)) & 32'd1; end
                    2: m_a[d] = ~(m_a[d] & src) & dmask;
                    4: m_a[d] = (m_a[d] ^ src) & dmask;
                    14: m_a[d] = src;
                    15: begin
                        if (r == 1) m_op[d] = m_a[d];
                        else if (r >= 2) m_r[d][r] = m_a[d];
                    end
                    default: ;
                endcase
            end
        endcase
        m_pc[d] = (m_pc[d] + 32'd1) & pmask;
    endtask

    task automatic check_all();
        chk("pc0",    32'(bus0.PC),    m_pc[0]);
        chk("oport0", 32'(bus0.OPORT), m_op[0]);
        chk("a0",     32'(dut0.a_q),   m_a[0]);
        chk("c0",     32'(dut0.c_q),   m_c[0]);
        chk("pc1",    32'(bus1.PC),    m_pc[1]);
        chk("oport1", 32'(bus1.OPORT), m_op[1]);
        chk("a1",     32'(dut1.a_q),   m_a[1]);
        chk("c1",     32'(dut1.c_q),   m_c[1]);
    endtask

    // One clock: dut d gets the instruction, the other core is stalled.
    task automatic step(input int d, input int unsigned instr, input int unsigned ip,
                        input bit iv, input bit rs);
        bus0.INSTR  = 8'(instr);
        bus1.INSTR  = 10'(instr);
        bus0.IPORT  = 4'(ip);
        bus1.IPORT  = 8'(ip);
        bus0.IVALID = (d == 0) && iv;
        bus1.IVALID = (d == 1) && iv;
        rst         = rs;
        @(posedge clk);
        #1;
        if (rs) model_reset();
        else if (iv) model_exec(d, instr, ip);
        check_all();
    endtask

    task automatic dir(input int d, input int unsigned instr, input int unsigned ip);
        step(d, instr, ip, 1'b1, 1'b0);
    endtask

    initial begin
        step(0, 0, 0, 1'b1, 1'b1);
        step(0, 'h47, 0, 1'b1, 1'b1);
        chk("rst_pc0", 32'(bus0.PC), 32'h0);
        chk("rst_a0", 32'(dut0.a_q), 32'h0);

        dir(0, 'h47, 0);           chk("addi7_a", 32'(dut0.a_q), 32'h7);
                                   chk("addi7_c", 32'(dut0.c_q), 32'h0);
        dir(0, 'h4C, 0);           chk("addi12_a", 32'(dut0.a_q), 32'h3);
                                   chk("addi12_c", 32'(dut0.c_q), 32'h1);
        dir(0, 'h08, 4);           chk("adc_a", 32'(dut0.a_q), 32'h8);
                                   chk("adc_c", 32'(dut0.c_q), 32'h0);
        dir(0, 'hD5, 0);           chk("br_taken", 32'(bus0.PC), 32'h55);
        dir(0, 'h90, 0);           chk("br_0x10", 32'(bus0.PC), 32'h10);
        dir(0, 'h6F, 0);           chk("xori_a", 32'(dut0.a_q), 32'h7);
        dir(0, 'hD5, 0);           chk("br_not_taken", 32'(bus0.PC), 32'h12);
        dir(0, 'h42, 0);
        dir(0, 'h79, 0);           chk("store_r1", 32'(bus0.OPORT), 32'h9);
        dir(0, 'h78, 5);           chk("store_r0_a", 32'(dut0.a_q), 32'h9);
        dir(0, 'h41, 0);
        dir(0, 'h71, 0);           chk("load_r1", 32'(dut0.a_q), 32'h9);
        dir(0, 'hFF, 0);           chk("br_0x7f", 32'(bus0.PC), 32'h7F);
        dir(0, 'h18, 0);           chk("pc_wrap", 32'(bus0.PC), 32'h0);
        for (int i = 0; i < 3; i++) step(0, 'h41, 0, 1'b0, 1'b0);
        chk("stall_a", 32'(dut0.a_q), 32'h9);
        chk("stall_pc", 32'(bus0.PC), 32'h0);
        step(0, 'h41, 0, 1'b1, 1'b1);
        chk("midrst_op", 32'(bus0.OPORT), 32'h0);

        dir(1, 'h70, 'hF5);
        dir(1, 'h4F, 0);           chk("w8_addi_a", 32'(dut1.a_q), 32'h04);
                                   chk("w8_addi_c", 32'(dut1.c_q), 32'h1);
        dir(1, 'h3FF, 0);          chk("w8_br_1ff", 32'(bus1.PC), 32'h1FF);
        dir(1, 'h4F, 0);           chk("w8_addi2_a", 32'(dut1.a_q), 32'h13);
                                   chk("w8_wrap", 32'(bus1.PC), 32'h0);
        dir(1, 'h70, 'h80);
        dir(1, 'h220, 0);          chk("c_br_not_taken", 32'(bus1.PC), 32'h2);
        dir(1, 'h70, 'hFF);
        dir(1, 'h41, 0);
        dir(1, 'h220, 0);          chk("c_br_taken", 32'(bus1.PC), 32'h20);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 400; i++) begin
                step(d, $urandom, $urandom, $urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
